data_cache_controller: RTL and testbench
========================================

Name: data_cache_controller

Overview:
- Memory-stage data cache that sits directly upstream of the MEM/WB pipeline register.
- Serves CPU loads and stores from a direct-mapped, write-through, no-write-allocate cache, and fills lines from main memory through a word-serial req/ack handshake.
- Drives `hit`, which the MEM/WB register uses as its advance enable; `hit`=0 stalls the pipeline while a miss or store is outstanding.

Parameters:
- LINES, 64, number of cache lines (power of 2).
- BLOCK_WORDS, 4, 32-bit words per line (power of 2, ≥2).
- ADDR_W, 32, byte-address width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- memRead  in  1  CPU load request.
- memWrite  in  1  CPU store request.
- address  in  ADDR_W  CPU byte address (word-aligned; bits [1:0] ignored).
- writeData  in  32  CPU store data.
- readData  out  32  load result, valid when hit=1 and memRead=1.
- hit  out  1  1 = access complete or no access; 0 = stall.
- memReq  out  1  request to main memory, held until memAck.
- memWe  out  1  1 = write request, 0 = read request.
- memAddr  out  ADDR_W  main-memory word address (byte units).
- memWdata  out  32  main-memory write data.
- memRdata  in  32  main-memory read data, valid with memAck.
- memAck  in  1  one-cycle acknowledge that completes the current word transfer.

Behaviour:
- Address split: [1:0] byte offset, next log2(BLOCK_WORDS) bits word offset, next log2(LINES) bits index, remainder tag.
- Storage: valid[LINES], tag array, data array.
  - Reset clears all valid bits only.
  - Tag and data arrays are not reset.
- Reset values: memReq=0, memWe=0, memAddr=0, memWdata=0, state=IDLE, fill counter=0.
  - hit=1 and readData=0 while no access is requested.
- States:
  - IDLE
    - Request lookup is combinational.
    - memWrite takes priority when memRead and memWrite are both 1.
    - Read hit (valid and tag match): hit=1, readData=selected word in the same cycle (zero-cycle latency); stay in IDLE.
    - Read miss: hit=0; next state FILL; counter=0.
    - Write (hit or miss): hit=0; next state WRITE.
  - FILL
    - hit=0, memReq=1, memWe=0, memAddr={tag,index,counter,2'b00}.
    - On memAck: store memRdata into line[index].word[counter]; counter++.
    - On the ack for the last word: set valid, write tag, go to IDLE.
    - The replayed lookup then hits. Read-miss latency = BLOCK_WORDS acks + 1 cycle.
    - Words are fetched in order 0..BLOCK_WORDS-1 (no critical-word-first).
    - The request is not restarted if address changes mid-fill; the CPU holds its inputs while hit=0.
  - WRITE
    - hit=0, memReq=1, memWe=1, memAddr=address, memWdata=writeData.
    - On memAck: if the line is valid and tags match, update that cached word; go to WDONE.
    - On a miss, no allocation and valid/tag are unchanged.
  - WDONE
    - hit=1 for exactly one cycle (the pipeline advances); memReq=0; next state IDLE.
    - Back-to-back stores therefore cost ≥3 cycles each.
- Handshake:
  - memReq, memWe, memAddr and memWdata are stable from assertion until the cycle memAck is sampled.
  - memReq deasserts in the cycle after the final ack of a transaction.
  - memAck while memReq=0 is ignored.
  - Consecutive fill words may be acked on consecutive cycles.
- Conflict: a read miss to a valid line with a different tag overwrites it; no writeback is needed because the cache is write-through.
- Reset mid-FILL or mid-WRITE: the next state is IDLE, memReq=0 from the cycle after reset is sampled, and all lines are invalid. A partially filled line is never marked valid.
- No access (memRead=memWrite=0): hit=1, readData=0, no state change.

Test Plan:
- Cold load from 0x100, memory returns words 0xA0..0xA3 for 0x100..0x10C with memAck 2 cycles after each memReq. Required:
  - hit=0 throughout the fill.
  - memAddr steps 0x100, 0x104, 0x108, 0x10C.
  - One cycle after the last ack, hit=1 and readData=0xA0.
- After that fill, load 0x108 → hit=1 and readData=0xA2 in the same cycle; memReq stays 0.
- Store 0xDEAD_BEEF to 0x104 (cached). Required:
  - memReq=1, memWe=1, memAddr=0x104, memWdata=0xDEADBEEF until ack.
  - hit=1 for one cycle.
  - A following load of 0x104 returns 0xDEADBEEF with no memory access.
- Store to uncached 0x2000 → memory write occurs; a following load of 0x2000 misses and triggers a FILL (no allocate).
- Conflict: load 0x100 (fills index 0), then load 0x100+LINES·BLOCK_WORDS·4 → refill of the same index; reloading 0x100 misses again.
- Reset asserted after the 2nd fill ack. Required:
  - memReq=0 the next cycle; hit=1.
  - Spurious memAck pulses are ignored.
  - Load 0x100 misses and restarts the fill at memAddr=0x100.

Source files
------------

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// hit doubles as the MEM/WB advance enable; line fills are word-serial over a req/ack port.
module data_cache_controller #(
    parameter int LINES       = 64,
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    output logic              hit,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWdata,
    input  logic [31:0]       memRdata,
    input  logic              memAck
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

    state_t           state, nextState;
    logic [OFF_W-1:0] fillCnt;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tagMem  [LINES];
    logic [31:0]      dataMem [LINES*BLOCK_WORDS];

    logic [TAG_W-1:0] addrTag;
    logic [IDX_W-1:0] addrIdx;
    logic [OFF_W-1:0] addrWord;
    logic             lineHit;
    logic             lastWord;

    assign addrTag  = address[ADDR_W-1 -: TAG_W];
    assign addrIdx  = address[2+OFF_W +: IDX_W];
    assign addrWord = address[2 +: OFF_W];
    assign lineHit  = valid[addrIdx] && (tagMem[addrIdx] == addrTag);
    assign lastWord = (fillCnt == OFF_W'(BLOCK_WORDS-1));

    // Valid is only set on the final fill ack, so a reset mid-fill never exposes a partial line.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            fillCnt <= '0;
            valid   <= '0;
        end else begin
            state <= nextState;
            if (state == FILL && memAck) begin
                fillCnt <= fillCnt + 1'b1;
                if (lastWord) valid[addrIdx] <= 1'b1;
            end else if (state != FILL) begin
                fillCnt <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == FILL && memAck) begin
                dataMem[{addrIdx, fillCnt}] <= memRdata;
                if (lastWord) tagMem[addrIdx] <= addrTag;
            end
            if (state == WRITE && memAck && lineHit)
                dataMem[{addrIdx, addrWord}] <= writeData;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (memWrite) nextState = WRITE;
                     else if (memRead && !lineHit) nextState = FILL;
            FILL:    if (memAck && lastWord) nextState = IDLE;
            WRITE:   if (memAck) nextState = WDONE;
            WDONE:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Memory-side outputs come straight from state; the CPU holds its inputs while stalled.
    always_comb begin
        hit      = 1'b1;
        readData = '0;
        memReq   = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = '0;
        case (state)
            IDLE: begin
                if (memWrite) begin
                    hit = 1'b0;
                end else if (memRead) begin
                    hit = lineHit;
                    if (lineHit) readData = dataMem[{addrIdx, addrWord}];
                end
            end
            FILL: begin
                hit     = 1'b0;
                memReq  = 1'b1;
                memAddr = {addrTag, addrIdx, fillCnt, 2'b00};
            end
            WRITE: begin
                hit      = 1'b0;
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = address;
                memWdata = writeData;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_data_cache_controller.sv
// Randomized bench for data_cache_controller: a behavioural memory responder plus a
// line-residency model predicts hit/miss, load data and the memory transactions.
module tb_data_cache_controller;
    localparam int LINES = 64;
    localparam int BW    = 4;
    localparam int OFF   = 2;
    localparam logic [31:0] CONFLICT = 32'(LINES*BW*4);

    logic        clock, reset, memRead, memWrite, hit, memReq, memWe, memAck;
    logic [31:0] address, writeData, readData, memAddr, memWdata, memRdata;

    data_cache_controller #(.LINES(LINES), .BLOCK_WORDS(BW), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .address(address), .writeData(writeData), .readData(readData), .hit(hit),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memAck(memAck)
    );

    int nChecks = 0, nPass = 0, cyc = 0;
    int fixedDelay = -1;
    bit spur = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] txAddr[$], txData[$];
    bit          txWe[$];
    int          txCyc[$];
    bit          lineVld  [LINES];
    logic [31:0] lineBase [LINES];

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] memRd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'd2654435761) ^ 32'h5A5A_0000;
    endfunction

    // Main memory: acks after a delay, logs every transfer with the cycle that samples its ack
    initial begin
        int ackWait;
        memAck = 0; memRdata = 0; ackWait = 0;
        forever begin
            @(negedge clock);
            memAck = 0;
            if (reset) ackWait = 0;
            else if (memReq) begin
                if (ackWait == 0) begin
                    memAck = 1;
                    txAddr.push_back(memAddr); txWe.push_back(memWe);
                    txData.push_back(memWdata); txCyc.push_back(cyc + 1);
                    if (memWe) mem[memAddr] = memWdata;
                    else memRdata = memRd(memAddr);
                    ackWait = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
                end else ackWait--;
            end else begin
                ackWait = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
                if (spur && $urandom_range(0, 1) == 1) memAck = 1;
            end
        end
    end

    task automatic waitHit(input string tag);
        int n = 0;
        while (!hit && n < 300) begin @(negedge clock); n++; end
        if (!hit) chk({tag, " timeout"}, 0, 1);
    endtask

    task automatic cpuLoad(input logic [31:0] a, input string tag);
        int idx = int'((a >> (2 + OFF)) % LINES);
        logic [31:0] base = a & ~32'(BW*4-1);
        bit expHit = lineVld[idx] && lineBase[idx] == base;
        logic [31:0] expData = memRd(a);
        int n0 = txAddr.size();
        @(posedge clock); #1;
        memRead = 1; memWrite = 0; address = a;
        @(negedge clock);
        chk({tag, " hit0"}, hit, expHit);
        waitHit(tag);
        chk({tag, " data"}, readData, expData);
        if (expHit) chk({tag, " noMemTx"}, txAddr.size(), n0);
        else begin
            chk({tag, " fillCount"}, txAddr.size(), n0 + BW);
            if (txAddr.size() == n0 + BW) begin
                for (int i = 0; i < BW; i++) begin
                    chk({tag, " fillAddr"}, txAddr[n0+i], base + 32'(4*i));
                    chk({tag, " fillWe"}, txWe[n0+i], 0);
                end
                chk({tag, " fillLatency"}, cyc, txCyc[n0+BW-1]);
            end
            lineVld[idx] = 1; lineBase[idx] = base;
        end
        @(posedge clock); #1;
        memRead = 0;
    endtask

    task automatic cpuStore(input logic [31:0] a, input logic [31:0] d, input bit both, input string tag);
        int n0 = txAddr.size();
        @(posedge clock); #1;
        memWrite = 1; memRead = both; address = a; writeData = d;
        @(negedge clock);
        chk({tag, " hit0"}, hit, 0);
        waitHit(tag);
        chk({tag, " wrCount"}, txAddr.size(), n0 + 1);
        if (txAddr.size() == n0 + 1) begin
            chk({tag, " wrAddr"}, txAddr[n0], a);
            chk({tag, " wrWe"}, txWe[n0], 1);
            chk({tag, " wrData"}, txData[n0], d);
            chk({tag, " wrLatency"}, cyc, txCyc[n0]);
        end
        @(posedge clock); #1;
        memWrite = 0; memRead = 0;
    endtask

    task automatic idleCheck(input string tag);
        @(posedge clock); #1;
        memRead = 0; memWrite = 0; address = $urandom;
        @(negedge clock);
        chk({tag, " hit"}, hit, 1);
        chk({tag, " rdata"}, readData, 0);
        chk({tag, " memReq"}, memReq, 0);
    endtask

    initial begin
        logic [31:0] pool [5];
        pool = '{32'h100, 32'h100 + CONFLICT, 32'h2000, 32'h3040, 32'h7FF0};
        for (int i = 0; i < LINES; i++) begin lineVld[i] = 0; lineBase[i] = 0; end
        for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4*i)] = 32'hA0 + 32'(i);
        reset = 1; memRead = 0; memWrite = 0; address = 0; writeData = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst hit", hit, 1);
        chk("rst rdata", readData, 0);
        chk("rst memReq", memReq, 0);
        chk("rst memWe", memWe, 0);
        chk("rst memAddr", memAddr, 0);
        chk("rst memWdata", memWdata, 0);
        @(posedge clock); #1 reset = 0;

        fixedDelay = 2;
        cpuLoad(32'h100, "coldLoad");
        fixedDelay = -1;
        cpuLoad(32'h108, "hitLoad");
        cpuStore(32'h104, 32'hDEADBEEF, 0, "storeHit");
        cpuLoad(32'h104, "loadAfterStore");
        cpuStore(32'h2000, 32'h1234_5678, 0, "storeMiss");
        cpuLoad(32'h2000, "noAllocLoad");
        cpuLoad(32'h100, "conflictA");
        cpuLoad(32'h100 + CONFLICT, "conflictB");
        cpuLoad(32'h100, "conflictReload");
        cpuStore(32'h108, 32'hCAFE_F00D, 1, "storePriority");
        cpuLoad(32'h108, "loadAfterPriority");
        idleCheck("idle");

        // Reset after the second ack of a fill of 0x100, then spurious acks while idle
        cpuLoad(32'h100 + CONFLICT, "evict");
        begin
            int n0 = txAddr.size();
            int t = 0;
            @(posedge clock); #1;
            memRead = 1; address = 32'h100;
            while (txAddr.size() < n0 + 2 && t < 100) begin @(posedge clock); t++; end
            if (txAddr.size() < n0 + 2) chk("midFill timeout", 0, 1);
            #1 reset = 1; memRead = 0;
            @(posedge clock);
            @(negedge clock);
            chk("midFillRst memReq", memReq, 0);
            chk("midFillRst hit", hit, 1);
            @(posedge clock); #1 reset = 0; spur = 1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                chk("spurAck memReq", memReq, 0);
                chk("spurAck hit", hit, 1);
            end
            spur = 0;
            for (int i = 0; i < LINES; i++) lineVld[i] = 0;
        end
        cpuLoad(32'h100, "loadAfterRst");

        for (int k = 0; k < 80; k++) begin
            logic [31:0] a = pool[$urandom_range(0, 4)] + 32'(4 * $urandom_range(0, BW-1));
            case ($urandom_range(0, 5))
                0, 1, 2: cpuLoad(a, "rndLoad");
                3, 4:    cpuStore(a, $urandom, 1'($urandom_range(0, 1)), "rndStore");
                default: idleCheck("rndIdle");
            endcase
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
